// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the pipeline boundary stage: occupancy state and the
// enable type used for the flush input.
package pipe_skid_stage_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_BUSY  = 2'd1,
      PS_FULL  = 2'd2
   } pipe_state_t;

   typedef enum logic {
      EN_OFF = 1'b0,
      EN_ON  = 1'b1
   } enable_t;

   // Number of held entries for a given state.
   function automatic logic [1:0] state_count(input pipe_state_t s);
      logic [1:0] c;
      c = 2'd0;
      case (s)
         PS_EMPTY: c = 2'd0;
         PS_BUSY:  c = 2'd1;
         PS_FULL:  c = 2'd2;
         default:  c = 2'd0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Generic pipeline boundary register with a two-entry skid buffer. Every output
// is a decode of flops, so no combinational path crosses the stage.
module pipe_skid_stage
   import pipe_skid_stage_pkg::*;
#(
   parameter int unsigned       WIDTH       = 64,
   parameter logic [WIDTH-1:0]  FLUSH_VALUE = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  enable_t           flush_c,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [1:0]        count_o,
   output pipe_state_t       dbg_state
);

   // Handshake: a beat transfers on a rising edge where valid and ready are
   // both high; valid never waits on ready, and ready never depends on valid.
   pipe_state_t       state_q;
   logic [WIDTH-1:0]  main_q;
   logic [WIDTH-1:0]  skid_q;
   logic              in_fire;
   logic              out_fire;

   assign in_ready  = (state_q != PS_FULL);
   assign out_valid = (state_q != PS_EMPTY);
   assign out_data  = main_q;
   assign count_o   = state_count(state_q);
   assign dbg_state = state_q;

   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= PS_EMPTY;
         main_q  <= FLUSH_VALUE;
         skid_q  <= FLUSH_VALUE;
      end else if (flush_c == EN_ON) begin
         // Flush wins over any fire this cycle; the input beat is dropped.
         state_q <= PS_EMPTY;
         main_q  <= FLUSH_VALUE;
         skid_q  <= FLUSH_VALUE;
      end else begin
         case (state_q)
            PS_EMPTY: begin
               if (in_fire) begin
                  main_q  <= in_data;
                  state_q <= PS_BUSY;
               end
            end
            PS_BUSY: begin
               if (in_fire && out_fire) begin
                  main_q <= in_data;
               end else if (in_fire) begin
                  skid_q  <= in_data;
                  state_q <= PS_FULL;
               end else if (out_fire) begin
                  // Vacated head is cleared so an empty stage shows FLUSH_VALUE.
                  main_q  <= FLUSH_VALUE;
                  state_q <= PS_EMPTY;
               end
            end
            PS_FULL: begin
               if (out_fire) begin
                  main_q  <= skid_q;
                  skid_q  <= FLUSH_VALUE;
                  state_q <= PS_BUSY;
               end
            end
            default: begin
               state_q <= PS_EMPTY;
               main_q  <= FLUSH_VALUE;
               skid_q  <= FLUSH_VALUE;
            end
         endcase
      end
   end

endmodule
